mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory port between the multicycle core and a boot loader.
//  Round-robin arbitration, one outstanding transaction at a time, and read-latency tracking.
//  Returns read data only to the requester that issued the read.
//  Sits between the core datapath's address/write-data outputs and the memory, under top.
// PARAMETERS
//  ADDR_W    32  address width, both requesters and memory
//  DATA_W    32  data width
//  RD_LAT    1   memory read latency in cycles (>=1); mem_rdata is valid RD_LAT cycles after a read issue
//  STALL_W   16  width of the CPU stall counter
// PORTS
//  clk          in   1        system clock, all state on rising edge
//  reset        in   1        synchronous, active-high
//  cpu_req      in   1        core requests the port
//  cpu_we       in   1        1 = write, 0 = read
//  cpu_addr     in   ADDR_W   core address
//  cpu_wdata    in   DATA_W   core write data
//  cpu_gnt      out  1        core transaction issued this cycle
//  cpu_rvalid   out  1        cpu_rdata valid (1-cycle pulse)
//  cpu_rdata    out  DATA_W   read data returned to core
//  ldr_req/ldr_we/ldr_addr/ldr_wdata/ldr_gnt/ldr_rvalid/ldr_rdata
//                             loader port, same widths/semantics as the cpu_* port
//  mem_en       out  1        memory access strobe
//  mem_we       out  1        memory write enable
//  mem_addr     out  ADDR_W   memory address
//  mem_wdata    out  DATA_W   memory write data
//  mem_rdata    in   DATA_W   memory read data
//  cpu_stall    out  STALL_W  saturating count of cycles with cpu_req=1 and cpu_gnt=0
// BEHAVIOUR
//  - States: IDLE, RD_WAIT. Reset -> IDLE, last_gnt=LDR, rd_owner=none, rd_cnt=0, cpu_stall=0.
//    All outputs 0 during and after reset.
//  - IDLE: grant is combinational in the same cycle as the request.
//    - Only one req: grant it.
//    - Both req: grant the requester that is not last_gnt.
//    - Granted requester: gnt=1 for exactly one cycle; mem_en=1 with mem_we/addr/wdata muxed from it.
//    - No req: mem_en=0 and mem_addr/wdata=0.
//  - Requester holds req/we/addr/wdata stable until gnt.
//    Deasserting req before gnt is legal; no transaction occurs and no state changes.
//  - Granted write: commits at the clock edge ending the grant cycle. Stay in IDLE, so back-to-back grants are possible.
//  - Granted read: -> RD_WAIT, rd_owner=granted side, rd_cnt=RD_LAT.
//  - RD_WAIT: no grants, mem_en=0, rd_cnt decrements each cycle.
//    - In the cycle rd_cnt==1: owner's rvalid=1 and rdata=mem_rdata; -> IDLE next edge.
//    - Read data therefore reaches the requester RD_LAT cycles after gnt.
//  - Non-owner rvalid stays 0 and its rdata holds 0.
//  - last_gnt updates on every grant.
//  - cpu_stall: +1 each cycle with cpu_req & !cpu_gnt; saturates at all-ones, no wrap.
//  - Reset in RD_WAIT: pending rvalid is dropped, no late pulse.
//  - Reset in a grant cycle: gnt forced 0, mem_en forced 0.
// CONFIGURATION
//  - ARB_LDR_LOCK_EN defined:
//    - Adds input ldr_lock (1).
//    - A loader grant while ldr_lock=1 sets a locked flag.
//    - While locked, cpu_gnt=0 regardless of round-robin; loader requests are granted whenever IDLE.
//    - The flag clears the first IDLE cycle with ldr_lock=0; from then on arbitration is normal round-robin.
//    - The flag is cleared by reset.
//  - ARB_LDR_LOCK_EN undefined: no ldr_lock port, no locked flag, pure round-robin.
// TESTING
//  1. Reset 3 cycles, no req -> all outputs 0, cpu_stall=0, mem_en=0.
//  2. cpu read 0x10, mem_rdata=0xDEADBEEF, RD_LAT=1 -> cpu_gnt in cycle T; cpu_rvalid=1 with 0xDEADBEEF in T+1; ldr_rvalid=0.
//  3. cpu and ldr both write every cycle from reset ->
//     grants alternate cpu,ldr,cpu,ldr; mem_addr follows the winner; cpu_stall increments on ldr cycles.
//  4. ldr read, then cpu req in the RD_WAIT cycle, RD_LAT=3 ->
//     cpu_gnt stays 0 for 3 cycles; ldr_rvalid after 3 cycles; cpu_gnt next cycle; cpu_stall=3.
//  5. cpu_req held while ldr_lock=1 (ARB_LDR_LOCK_EN), 8 loader writes ->
//     cpu_gnt=0 throughout; cpu granted 1 cycle after lock drops.
//  6. Reset asserted in RD_WAIT -> no rvalid pulse afterwards; first post-reset tie goes to cpu.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single unified memory port between the core
// (cpu_*) and the boot loader (ldr_*). Round-robin arbitration, one
// outstanding transaction, read data steered back to the issuing requester
// after RD_LAT cycles, plus a saturating core stall counter.
// Optional feature macro: ARB_LDR_LOCK_EN (adds ldr_lock, lets the loader
// lock the core out of the port).
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RD_LAT  = 1,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic               cpu_gnt,
  output logic               cpu_rvalid,
  output logic [DATA_W-1:0]  cpu_rdata,
  input  logic               ldr_req,
  input  logic               ldr_we,
  input  logic [ADDR_W-1:0]  ldr_addr,
  input  logic [DATA_W-1:0]  ldr_wdata,
`ifdef ARB_LDR_LOCK_EN
  input  logic               ldr_lock,
`endif
  output logic               ldr_gnt,
  output logic               ldr_rvalid,
  output logic [DATA_W-1:0]  ldr_rdata,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [STALL_W-1:0] cpu_stall
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic {IDLE, RD_WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_LDR} owner_t;

  state_t             state_q, state_d;
  logic               last_ldr_q;   // 1 = loader won the last grant
  owner_t             rd_owner_q;
  logic [CNT_W-1:0]   rd_cnt_q;
  logic               cpu_block;
  logic               rd_issue;
  logic               rd_done;

`ifdef ARB_LDR_LOCK_EN
  logic locked_q;
  assign cpu_block = locked_q;

  // Lock engages on a loader grant with ldr_lock high, releases on the first idle cycle without it.
  always_ff @(posedge clk) begin
    if (reset)                                 locked_q <= 1'b0;
    else if (ldr_gnt && ldr_lock)              locked_q <= 1'b1;
    else if (state_q == IDLE && !ldr_lock)     locked_q <= 1'b0;
  end
`else
  assign cpu_block = 1'b0;
`endif

  assign rd_issue = (cpu_gnt && !cpu_we) || (ldr_gnt && !ldr_we);
  assign rd_done  = (state_q == RD_WAIT) && (rd_cnt_q == CNT_W'(1)) && !reset;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: a read grant parks us in RD_WAIT until the data cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_issue) state_d = RD_WAIT;
      RD_WAIT: if (rd_cnt_q == CNT_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: same-cycle grant and port mux in IDLE, owner-steered read return in RD_WAIT.
  always_comb begin
    logic cpu_ok;
    cpu_ok     = cpu_req && !cpu_block;
    cpu_gnt    = 1'b0;
    ldr_gnt    = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cpu_rvalid = 1'b0;
    cpu_rdata  = '0;
    ldr_rvalid = 1'b0;
    ldr_rdata  = '0;
    if (state_q == IDLE && !reset) begin
      // On a tie the side that did not win last time gets the port.
      cpu_gnt = cpu_ok && (!ldr_req || last_ldr_q);
      ldr_gnt = ldr_req && (!cpu_ok || !last_ldr_q);
    end
    if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ldr_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ldr_we;
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
    end
    if (rd_done && rd_owner_q == OWN_CPU) begin
      cpu_rvalid = 1'b1;
      cpu_rdata  = mem_rdata;
    end
    if (rd_done && rd_owner_q == OWN_LDR) begin
      ldr_rvalid = 1'b1;
      ldr_rdata  = mem_rdata;
    end
  end

  // Arbitration history, read tracking and the saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_ldr_q <= 1'b1;
      rd_owner_q <= OWN_NONE;
      rd_cnt_q   <= '0;
      cpu_stall  <= '0;
    end else begin
      if (cpu_gnt)      last_ldr_q <= 1'b0;
      else if (ldr_gnt) last_ldr_q <= 1'b1;
      if (rd_issue) begin
        rd_owner_q <= cpu_gnt ? OWN_CPU : OWN_LDR;
        rd_cnt_q   <= CNT_W'(RD_LAT);
      end else if (state_q == RD_WAIT) begin
        rd_cnt_q <= rd_cnt_q - CNT_W'(1);
        if (rd_cnt_q == CNT_W'(1)) rd_owner_q <= OWN_NONE;
      end
      if (cpu_req && !cpu_gnt && cpu_stall != {STALL_W{1'b1}})
        cpu_stall <= cpu_stall + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a table of single-cycle vectors against an
// RD_LAT=1 instance, plus hand-written multi-cycle sequences against an
// RD_LAT=3 instance (read-wait stall, reset during read wait, loader lock).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, ldr_req, ldr_we;
  logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata, mem_rdata;
`ifdef ARB_LDR_LOCK_EN
  logic        ldr_lock;
`endif

  logic        d1_cpu_gnt, d1_cpu_rvalid, d1_ldr_gnt, d1_ldr_rvalid, d1_mem_en, d1_mem_we;
  logic [31:0] d1_cpu_rdata, d1_ldr_rdata, d1_mem_addr, d1_mem_wdata;
  logic [15:0] d1_cpu_stall;
  logic        d3_cpu_gnt, d3_cpu_rvalid, d3_ldr_gnt, d3_ldr_rvalid, d3_mem_en, d3_mem_we;
  logic [31:0] d3_cpu_rdata, d3_ldr_rdata, d3_mem_addr, d3_mem_wdata;
  logic [15:0] d3_cpu_stall;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .STALL_W(16)) dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(d1_cpu_gnt), .cpu_rvalid(d1_cpu_rvalid), .cpu_rdata(d1_cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
`ifdef ARB_LDR_LOCK_EN
    .ldr_lock(ldr_lock),
`endif
    .ldr_gnt(d1_ldr_gnt), .ldr_rvalid(d1_ldr_rvalid), .ldr_rdata(d1_ldr_rdata),
    .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata),
    .mem_rdata(mem_rdata), .cpu_stall(d1_cpu_stall)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .STALL_W(16)) dut3 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(d3_cpu_gnt), .cpu_rvalid(d3_cpu_rvalid), .cpu_rdata(d3_cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
`ifdef ARB_LDR_LOCK_EN
    .ldr_lock(ldr_lock),
`endif
    .ldr_gnt(d3_ldr_gnt), .ldr_rvalid(d3_ldr_rvalid), .ldr_rdata(d3_ldr_rdata),
    .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr), .mem_wdata(d3_mem_wdata),
    .mem_rdata(mem_rdata), .cpu_stall(d3_cpu_stall)
  );

  typedef struct packed {
    logic rst; logic cr; logic cw; logic [31:0] ca; logic [31:0] cd;
    logic lr; logic lw; logic [31:0] la; logic [31:0] ld; logic [31:0] mrd;
  } stim_t;

  typedef struct packed {
    logic cg; logic lg; logic en; logic we; logic [31:0] ma; logic [31:0] md;
    logic crv; logic [31:0] crd; logic lrv; logic [31:0] lrd; logic [15:0] st;
  } exp_t;

  typedef struct packed { stim_t s; exp_t e; } vec_t;

  localparam int NV = 16;
  vec_t tv [NV];

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr_in();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0; mem_rdata = 0;
`ifdef ARB_LDR_LOCK_EN
    ldr_lock = 0;
`endif
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    nxt(); clr_in(); reset = 1;
    repeat (n) nxt();
    reset = 0;
  endtask

  function automatic exp_t d1_act();
    exp_t a;
    a = '{d1_cpu_gnt, d1_ldr_gnt, d1_mem_en, d1_mem_we, d1_mem_addr, d1_mem_wdata,
          d1_cpu_rvalid, d1_cpu_rdata, d1_ldr_rvalid, d1_ldr_rdata, d1_cpu_stall};
    return a;
  endfunction

  initial begin
    reset = 1;
    clr_in();
    //            rst cr cw ca      cd     lr lw la       ld      mrd              cg lg en we ma       md     crv crd             lrv lrd st
    tv[0]  = '{'{1,0,0,32'h0,  32'h0, 0,0,32'h0,  32'h0,  32'h0},        '{0,0,0,0,32'h0,  32'h0, 0,32'h0,        0,32'h0,16'd0}};
    tv[1]  = tv[0];
    tv[2]  = '{'{1,1,1,32'h10, 32'h5, 1,1,32'h20, 32'h6,  32'h0},        '{0,0,0,0,32'h0,  32'h0, 0,32'h0,        0,32'h0,16'd0}};
    tv[3]  = '{'{0,1,0,32'h10, 32'h0, 0,0,32'h0,  32'h0,  32'h0},        '{1,0,1,0,32'h10, 32'h0, 0,32'h0,        0,32'h0,16'd0}};
    tv[4]  = '{'{0,0,0,32'h0,  32'h0, 1,1,32'h20, 32'h77, 32'hDEADBEEF}, '{0,0,0,0,32'h0,  32'h0, 1,32'hDEADBEEF, 0,32'h0,16'd0}};
    tv[5]  = '{'{0,0,0,32'h0,  32'h0, 1,1,32'h20, 32'h77, 32'hDEADBEEF}, '{0,1,1,1,32'h20, 32'h77,0,32'h0,        0,32'h0,16'd0}};
    tv[6]  = '{'{0,1,1,32'h100,32'hA, 1,1,32'h200,32'hB,  32'h0},        '{1,0,1,1,32'h100,32'hA, 0,32'h0,        0,32'h0,16'd0}};
    tv[7]  = '{tv[6].s,                                                  '{0,1,1,1,32'h200,32'hB, 0,32'h0,        0,32'h0,16'd0}};
    tv[8]  = '{tv[6].s,                                                  '{1,0,1,1,32'h100,32'hA, 0,32'h0,        0,32'h0,16'd1}};
    tv[9]  = '{tv[6].s,                                                  '{0,1,1,1,32'h200,32'hB, 0,32'h0,        0,32'h0,16'd1}};
    tv[10] = '{tv[6].s,                                                  '{1,0,1,1,32'h100,32'hA, 0,32'h0,        0,32'h0,16'd2}};
    tv[11] = '{'{0,0,0,32'h0,  32'h0, 0,0,32'h0,  32'h0,  32'h0},        '{0,0,0,0,32'h0,  32'h0, 0,32'h0,        0,32'h0,16'd2}};
    tv[12] = '{'{0,1,0,32'h44, 32'h0, 0,0,32'h0,  32'h0,  32'h0},        '{1,0,1,0,32'h44, 32'h0, 0,32'h0,        0,32'h0,16'd2}};
    tv[13] = '{'{0,1,1,32'h100,32'hA, 1,1,32'h200,32'hB,  32'h12345678}, '{0,0,0,0,32'h0,  32'h0, 1,32'h12345678, 0,32'h0,16'd2}};
    tv[14] = '{tv[6].s,                                                  '{0,1,1,1,32'h200,32'hB, 0,32'h0,        0,32'h0,16'd3}};
    tv[15] = '{tv[6].s,                                                  '{1,0,1,1,32'h100,32'hA, 0,32'h0,        0,32'h0,16'd4}};

    // Table: one vector per cycle, inputs after the edge, outputs at the falling edge.
    for (int i = 0; i < NV; i++) begin
      nxt();
      reset = tv[i].s.rst;
      cpu_req = tv[i].s.cr; cpu_we = tv[i].s.cw; cpu_addr = tv[i].s.ca; cpu_wdata = tv[i].s.cd;
      ldr_req = tv[i].s.lr; ldr_we = tv[i].s.lw; ldr_addr = tv[i].s.la; ldr_wdata = tv[i].s.ld;
      mem_rdata = tv[i].s.mrd;
      @(negedge clk);
      chk($sformatf("vec%0d", i), d1_act(), tv[i].e);
    end

    // Loader read with RD_LAT=3 while the core waits behind it.
    do_reset(2);
    ldr_req = 1; ldr_we = 0; ldr_addr = 32'h30;
    @(negedge clk);
    chk("rl3_ldr_gnt", d3_ldr_gnt, 1);
    for (int k = 0; k < 3; k++) begin
      nxt();
      ldr_req = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'h99;
      mem_rdata = (k == 2) ? 32'hCAFEF00D : 32'h0;
      @(negedge clk);
      chk($sformatf("rl3_cpu_blocked%0d", k), d3_cpu_gnt, 0);
      chk($sformatf("rl3_ldr_rvalid%0d", k), {d3_ldr_rvalid, d3_ldr_rdata, d3_cpu_rvalid},
          (k == 2) ? {1'b1, 32'hCAFEF00D, 1'b0} : 34'h0);
    end
    nxt();
    mem_rdata = 0;
    @(negedge clk);
    chk("rl3_cpu_gnt_after", {d3_cpu_gnt, d3_mem_addr}, {1'b1, 32'h40});
    chk("rl3_cpu_stall", d3_cpu_stall, 16'd3);

    // Reset while a read is pending: the return pulse must never appear.
    do_reset(2);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h50;
    @(negedge clk);
    chk("rst_rd_gnt", d3_cpu_gnt, 1);
    nxt();
    clr_in(); reset = 1; mem_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    chk("rst_rd_forced", {d3_cpu_rvalid, d3_mem_en, d3_cpu_gnt}, 3'b000);
    nxt();
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rst_no_rvalid%0d", k), {d3_cpu_rvalid, d3_ldr_rvalid}, 2'b00);
      nxt();
    end
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h60; ldr_req = 1; ldr_we = 1; ldr_addr = 32'h70;
    @(negedge clk);
    chk("rst_tie_cpu", {d3_cpu_gnt, d3_ldr_gnt, d3_mem_addr}, {2'b10, 32'h60});

`ifdef ARB_LDR_LOCK_EN
    // Loader lock: core locked out while the loader streams writes.
    do_reset(2);
    ldr_lock = 1; ldr_req = 1; ldr_we = 1; ldr_addr = 32'h300;
    @(negedge clk);
    chk("lock_first_ldr", d1_ldr_gnt, 1);
    for (int k = 0; k < 7; k++) begin
      nxt();
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h400; ldr_addr = 32'h301 + k;
      @(negedge clk);
      chk($sformatf("lock_hold%0d", k), {d1_cpu_gnt, d1_ldr_gnt}, 2'b01);
    end
    nxt();
    ldr_req = 0; ldr_lock = 0;
    @(negedge clk);
    chk("lock_drop_cycle", d1_cpu_gnt, 0);
    nxt();
    @(negedge clk);
    chk("lock_released", {d1_cpu_gnt, d1_mem_addr}, {1'b1, 32'h400});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
